// File: rtl/keypad_scan_bcd.sv
// keypad_scan_bcd: 4x4 matrix keypad scanner with debounce and a two-digit display bus.
// One column is driven low per slot. A row seen low on a slot tick is debounced,
// then emitted. BCD_disp carries {previous code, newest code}.
// Optional feature: define KEY_AUTOREPEAT_EN to re-emit a held key every REPEAT_TICKS ticks.
//
// state    | meaning
// SCAN     | stepping columns, looking for exactly one closed row
// DEBOUNCE | column frozen, candidate must match on consecutive ticks
// HOLD     | key accepted, waiting for a debounced release
`timescale 1ns/1ps
module keypad_scan_bcd #(
  parameter int SCAN_CNTMAX  = 49_999,
  parameter int DEB_TICKS    = 20,
  parameter int REPEAT_TICKS = 500
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] BCD_disp
);

  localparam int SLOT_W = $clog2(SCAN_CNTMAX + 1);
  localparam int DEB_W  = $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t            state, state_next;
  logic [3:0]        row_meta, row_sync;
  logic [SLOT_W-1:0] slot_cnt;
  logic              tick;
  logic [1:0]        col_idx, col_next;
  logic [1:0]        cand_row, cand_next;
  logic [DEB_W-1:0]  deb_cnt, deb_next;
  logic [DEB_W-1:0]  rel_cnt, rel_next;
  logic              one_low;
  logic [1:0]        row_idx;
  logic [3:0]        cand_pat;
  logic              emit;
  logic [3:0]        emit_code;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS);
  logic [REP_W-1:0] rep_cnt, rep_next;
`endif

  assign tick     = (slot_cnt == SLOT_W'(SCAN_CNTMAX));
  assign key_col  = ~(4'b0001 << col_idx);
  assign cand_pat = ~(4'b0001 << cand_row);

  // Two-flop synchronizer for the asynchronous row inputs (idle high).
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  // Slot counter; the tick marks the last cycle of each column slot.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst)       slot_cnt <= '0;
    else if (tick) slot_cnt <= '0;
    else           slot_cnt <= slot_cnt + 1'b1;
  end

  // Decode a single closed row; zero or several closed rows are treated as no key.
  always_comb begin
    one_low = 1'b0;
    row_idx = 2'd0;
    unique case (~row_sync)
      4'b0001: begin one_low = 1'b1; row_idx = 2'd0; end
      4'b0010: begin one_low = 1'b1; row_idx = 2'd1; end
      4'b0100: begin one_low = 1'b1; row_idx = 2'd2; end
      4'b1000: begin one_low = 1'b1; row_idx = 2'd3; end
      default: begin one_low = 1'b0; row_idx = 2'd0; end
    endcase
  end

  // Next-state logic; everything advances only on a slot tick.
  always_comb begin
    state_next = state;
    col_next   = col_idx;
    cand_next  = cand_row;
    deb_next   = deb_cnt;
    rel_next   = rel_cnt;
    emit       = 1'b0;
    emit_code  = {cand_row, col_idx};
`ifdef KEY_AUTOREPEAT_EN
    rep_next   = rep_cnt;
`endif
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (one_low) begin
            cand_next  = row_idx;
            deb_next   = DEB_W'(1);
            state_next = DEBOUNCE;
          end else begin
            col_next = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_sync == cand_pat) begin
            if (deb_cnt == DEB_W'(DEB_TICKS)) begin
              emit       = 1'b1;
              rel_next   = '0;
              state_next = HOLD;
`ifdef KEY_AUTOREPEAT_EN
              rep_next   = '0;
`endif
            end else begin
              deb_next = deb_cnt + 1'b1;
            end
          end else begin
            col_next   = col_idx + 2'd1;
            state_next = SCAN;
          end
        end
        HOLD: begin
          if (row_sync == 4'hF) begin
`ifdef KEY_AUTOREPEAT_EN
            rep_next = '0;
`endif
            if (rel_cnt == DEB_W'(DEB_TICKS)) begin
              rel_next   = '0;
              col_next   = col_idx + 2'd1;
              state_next = SCAN;
            end else begin
              rel_next = rel_cnt + 1'b1;
            end
          end else begin
            rel_next = '0;
`ifdef KEY_AUTOREPEAT_EN
            if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
              emit     = 1'b1;
              rep_next = '0;
            end else begin
              rep_next = rep_cnt + 1'b1;
            end
`endif
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      cand_row <= 2'd0;
      deb_cnt  <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_next;
      col_idx  <= col_next;
      cand_row <= cand_next;
      deb_cnt  <= deb_next;
      rel_cnt  <= rel_next;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Auto-repeat tick counter while the key stays closed.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) rep_cnt <= '0;
    else     rep_cnt <= rep_next;
  end
`endif

  // Output registers: pulse, latched code and the shifting display bus.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      BCD_disp  <= 8'h00;
    end else begin
      key_valid <= emit;
      if (emit) begin
        key_code <= emit_code;
        BCD_disp <= {BCD_disp[3:0], emit_code};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_bcd.sv
// Testbench for keypad_scan_bcd with short slots; a keypad model shorts a pressed
// row to the column currently driven low. Expected codes come from a history queue.
`timescale 1ns/1ps
module tb_keypad_scan_bcd;

  localparam int SCAN_CNTMAX  = 9;
  localparam int DEB_TICKS    = 4;
  localparam int REPEAT_TICKS = 8;
  localparam int SLOT         = SCAN_CNTMAX + 1;
  localparam int LATENCY      = SLOT * (DEB_TICKS + 1);

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] BCD_disp;

  logic [15:0] pressed = 16'h0000;
  int total = 0;
  int bad = 0;
  logic [3:0] hist[$];

  keypad_scan_bcd #(
    .SCAN_CNTMAX(SCAN_CNTMAX),
    .DEB_TICKS(DEB_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk_50M(clk_50M),
    .rst(rst),
    .key_row(key_row),
    .key_col(key_col),
    .key_valid(key_valid),
    .key_code(key_code),
    .BCD_disp(BCD_disp)
  );

  always #5 clk_50M = ~clk_50M;

  // Keypad matrix: a closed switch pulls its row low when its column is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  function automatic logic [7:0] model_disp();
    logic [3:0] prev;
    logic [3:0] last;
    prev = (hist.size() >= 2) ? hist[hist.size()-2] : 4'h0;
    last = (hist.size() >= 1) ? hist[hist.size()-1] : 4'h0;
    return {prev, last};
  endfunction

  // Wait for the scan to move onto column c (bounded).
  task automatic wait_col(input int c);
    logic [3:0] prev;
    logic [3:0] target;
    int found;
    target = ~(4'b0001 << c);
    found = 0;
    for (int k = 0; k < 80 && found == 0; k++) begin
      prev = key_col;
      step();
      if (key_col != prev && key_col == target) found = 1;
    end
    chk("wait_col", found, 1);
  endtask

  // Run n cycles, optionally bouncing the masked switch, and check every emission.
  task automatic watch(input int n, input logic [15:0] mask, input logic [3:0] exp_code,
                       input int bounce, output int pulses, output int first);
    pulses = 0;
    first = -1;
    for (int k = 1; k <= n; k++) begin
      if (bounce > 0 && k <= bounce && (k % 3) == 0) pressed = pressed ^ mask;
      if (bounce > 0 && k == bounce + 1) pressed = pressed | mask;
      step();
      if (key_valid) begin
        pulses++;
        if (first < 0) first = k;
        hist.push_back(exp_code);
        chk("key_code", key_code, exp_code);
        chk("bcd_disp", BCD_disp, model_disp());
      end
    end
  endtask

  // Clean press at the start of the key's column slot, hold, release.
  task automatic press_clean(input int r, input int c, input int hold, input int exp_pulses);
    logic [15:0] mask;
    logic [3:0] code;
    logic [3:0] col_exp;
    int p1, f1, p2, f2;
    mask = 16'h0001 << (r*4 + c);
    code = 4'(r*4 + c);
    col_exp = ~(4'b0001 << c);
    wait_col(c);
    pressed = pressed | mask;
    watch(hold, mask, code, 0, p1, f1);
    chk("latency", f1, LATENCY);
    chk("col_frozen", key_col, col_exp);
    chk("code_held", key_code, code);
    pressed = pressed & ~mask;
    watch(80, mask, code, 0, p2, f2);
    chk("pulse_count", p1 + p2, exp_pulses);
  endtask

  initial begin
    int p, f, r, c;
    logic [3:0] colseq [4];
    logic [15:0] mask;
    int found, steps;
    logic [3:0] prev;
    int rep_exp;
    colseq[0] = 4'b1110; colseq[1] = 4'b1101; colseq[2] = 4'b1011; colseq[3] = 4'b0111;

    // Reset values and column walk.
    step(); step(); step();
    chk("rst_col", key_col, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_disp", BCD_disp, 8'h00);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      found = 0;
      steps = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
        prev = key_col;
        step();
        steps++;
        if (key_col != prev) found = 1;
      end
      chk("col_step_time", steps, SLOT);
      chk("col_seq", key_col, colseq[i % 4]);
    end

    // Reset pulse mid-slot returns to reset values immediately.
    step(); step(); step(); step();
    rst = 1'b1;
    #1;
    chk("midrst_col", key_col, 4'b1110);
    chk("midrst_valid", key_valid, 1'b0);
    chk("midrst_disp", BCD_disp, 8'h00);
    step();
    rst = 1'b0;

    // Row 1 / column 2, clean press.
    press_clean(1, 2, 100, 1);
    chk("disp_06", BCD_disp, 8'h06);

    // Row 3 / column 0 with contact bounce before settling.
    mask = 16'h0001 << 12;
    wait_col(0);
    watch(300, mask, 4'hC, 20, p, f);
    chk("bounce_pulses", p, 1);
    chk("disp_6c", BCD_disp, 8'h6C);
    pressed = 16'h0000;
    watch(80, mask, 4'hC, 0, p, f);
    chk("bounce_release", p, 0);

    // Short press (two ticks) on row 0 / column 1 is rejected.
    mask = 16'h0001 << 1;
    wait_col(1);
    pressed = mask;
    watch(20, mask, 4'h1, 0, p, f);
    pressed = 16'h0000;
    watch(200, mask, 4'h1, 0, f, steps);
    chk("short_press", p + f, 0);
    chk("short_disp", BCD_disp, 8'h6C);

    // Two keys in one column (ghosting) are ignored.
    pressed = (16'h0001 << 2) | (16'h0001 << 14);
    watch(300, 16'h0000, 4'h2, 0, p, f);
    chk("two_keys", p, 0);
    pressed = 16'h0000;
    watch(30, 16'h0000, 4'h2, 0, p, f);

    // Random single keys, then the same key again.
    r = 0; c = 0;
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press_clean(r, c, 100, 1);
    end
    press_clean(r, c, 100, 1);
    chk("same_twice", BCD_disp, {2{4'(r*4 + c)}});

    // Reset while holding a key: outputs clear, the key is re-detected once.
    mask = 16'h0001 << 9;
    wait_col(1);
    pressed = mask;
    watch(60, mask, 4'h9, 0, p, f);
    chk("hold_accept", p, 1);
    rst = 1'b1;
    #1;
    chk("hold_rst_valid", key_valid, 1'b0);
    chk("hold_rst_code", key_code, 4'h0);
    chk("hold_rst_disp", BCD_disp, 8'h00);
    chk("hold_rst_col", key_col, 4'b1110);
    hist.delete();
    step(); step();
    rst = 1'b0;
    watch(150, mask, 4'h9, 0, p, f);
    chk("redetect_pulses", p, 1);
    chk("redetect_disp", BCD_disp, 8'h09);
    pressed = 16'h0000;
    watch(80, mask, 4'h9, 0, p, f);
    chk("redetect_release", p, 0);

    // Long hold of key 5 for 30 ticks.
`ifdef KEY_AUTOREPEAT_EN
    rep_exp = 4;
`else
    rep_exp = 1;
`endif
    press_clean(1, 1, 30 * SLOT, rep_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
